// File: rtl/alu_chk_pkg.sv
// Shared definitions for the ALU vector checker: FSM state encoding and packed-vector field offsets.
// Vectors are packed {A, B, EXP}, with EXP in the least significant DATA_W bits.
package alu_chk_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        SETTLE = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5
    } chk_state_t;

    localparam int EXP_LSB = 0;

    function automatic int a_lsb(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int b_lsb(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/alu_vector_checker_settle_timer.sv
// chk_settle_timer: loadable down-counter that gives the unit under test SETTLE_CYC cycles to settle.
// Load takes effect next cycle; expired is high whenever the count has reached zero.
module chk_settle_timer #(
    parameter int SETTLE_CYC = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic expired
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(SETTLE_CYC - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/alu_vector_checker.sv
// alu_vector_checker: applies ROM vectors to a combinational ALU unit, checks results, keeps pass/fail stats.
// Per vector 3+SETTLE_CYC cycles; define ALU_CHK_STOP_ON_FAIL_EN to end the run at the first failing vector.
module alu_vector_checker
    import alu_chk_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_VEC    = 20,
    parameter int ADDR_W     = 5,
    parameter int SETTLE_CYC = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic [ADDR_W-1:0]   vec_addr,
    input  logic [3*DATA_W-1:0] vec_data,
    output logic [DATA_W-1:0]   dut_a,
    output logic [DATA_W-1:0]   dut_b,
    input  logic [DATA_W-1:0]   dut_out,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     pass_cnt,
    output logic [ADDR_W:0]     fail_cnt,
    output logic [ADDR_W-1:0]   first_fail,
    output logic                all_pass
);

    localparam int                A_LSB    = a_lsb(DATA_W);
    localparam int                B_LSB    = b_lsb(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);

    chk_state_t        state;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] exp_q;
    logic              settle_expired;
    logic              chk_ok;
    logic              chk_finish;

    chk_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle (
        .clock   (clock),
        .reset   (reset),
        .load    (state == LOAD),
        .expired (settle_expired)
    );

    // An X/Z result makes chk_ok unknown, which every if below treats as a failure.
    assign chk_ok = (dut_out == exp_q);

    always_comb begin
        chk_finish = (idx == LAST_IDX);
`ifdef ALU_CHK_STOP_ON_FAIL_EN
        if (chk_ok) begin
            chk_finish = (idx == LAST_IDX);
        end else begin
            chk_finish = 1'b1;
        end
`endif
    end

    // vec_addr is presented on entry to FETCH so the 1-cycle ROM data lands in LOAD.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            vec_addr   <= '0;
            dut_a      <= '0;
            dut_b      <= '0;
            exp_q      <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            first_fail <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= FETCH;
                        idx        <= '0;
                        vec_addr   <= '0;
                        pass_cnt   <= '0;
                        fail_cnt   <= '0;
                        first_fail <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                FETCH: begin
                    vec_addr <= idx;
                    state    <= LOAD;
                end
                LOAD: begin
                    dut_a <= vec_data[A_LSB +: DATA_W];
                    dut_b <= vec_data[B_LSB +: DATA_W];
                    exp_q <= vec_data[EXP_LSB +: DATA_W];
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (settle_expired) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (chk_ok) begin
                        pass_cnt <= pass_cnt + (ADDR_W+1)'(1);
                    end else begin
                        fail_cnt <= fail_cnt + (ADDR_W+1)'(1);
                        if (fail_cnt == '0) begin
                            first_fail <= idx;
                        end
                    end
                    // idx stays on the last address rather than wrapping.
                    if (chk_finish) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= FETCH;
                        idx      <= idx + ADDR_W'(1);
                        vec_addr <= idx + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign all_pass = done && (fail_cnt == '0);

endmodule

// File: tb/tb_alu_vector_checker.sv
// Bench: 1-cycle synchronous ROM model feeding an or32 unit, plus a single-vector instance.
module tb_alu_vector_checker;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        start1;

    logic [4:0]  vec_addr, vec_addr1;
    logic [95:0] vec_data, vec_data1;
    logic [31:0] dut_a, dut_b, dut_out, a1, b1, out1;
    logic        busy, done, all_pass, busy1, done1, all_pass1;
    logic [5:0]  pass_cnt, fail_cnt, pass1, fail1;
    logic [4:0]  first_fail, ff1;

    logic [95:0] golden [20];
    logic [95:0] rom [20];
    logic [95:0] rom1;

    int tests = 0;
    int fails = 0;

    alu_vector_checker #(
        .DATA_W(32), .NUM_VEC(20), .ADDR_W(5), .SETTLE_CYC(2)
    ) u_dut (
        .clock(clk), .reset(rst_n), .start(start), .vec_addr(vec_addr), .vec_data(vec_data),
        .dut_a(dut_a), .dut_b(dut_b), .dut_out(dut_out), .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail(first_fail), .all_pass(all_pass)
    );

    alu_vector_checker #(
        .DATA_W(32), .NUM_VEC(1), .ADDR_W(5), .SETTLE_CYC(1)
    ) u_one (
        .clock(clk), .reset(rst_n), .start(start1), .vec_addr(vec_addr1), .vec_data(vec_data1),
        .dut_a(a1), .dut_b(b1), .dut_out(out1), .busy(busy1), .done(done1),
        .pass_cnt(pass1), .fail_cnt(fail1), .first_fail(ff1), .all_pass(all_pass1)
    );

    always_ff @(posedge clk) vec_data  <= (vec_addr < 5'd20) ? rom[vec_addr] : '0;
    always_ff @(posedge clk) vec_data1 <= (vec_addr1 == 5'd0) ? rom1 : '0;
    assign dut_out = dut_a | dut_b;
    assign out1    = a1 | b1;

    task automatic init_vectors();
        golden[0]  = {32'h12345678, 32'h87654321, 32'h97755779};
        golden[1]  = {32'h00000000, 32'h00000000, 32'h00000000};
        golden[2]  = {32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
        golden[3]  = {32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        golden[4]  = {32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF};
        golden[5]  = {32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF};
        golden[6]  = {32'hF0F0F0F0, 32'h00FF00FF, 32'hF0FFF0FF};
        golden[7]  = {32'h80000000, 32'h00000001, 32'h80000001};
        golden[8]  = {32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFF};
        golden[9]  = {32'h12340000, 32'h00005678, 32'h12345678};
        golden[10] = {32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF};
        golden[11] = {32'h01010101, 32'h10101010, 32'h11111111};
        golden[12] = {32'h11111111, 32'h22222222, 32'h33333333};
        golden[13] = {32'h44444444, 32'h88888888, 32'hCCCCCCCC};
        golden[14] = {32'h89ABCDEF, 32'h00000000, 32'h89ABCDEF};
        golden[15] = {32'h00000001, 32'h00000002, 32'h00000003};
        golden[16] = {32'hCAFE0000, 32'h0000BABE, 32'hCAFEBABE};
        golden[17] = {32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F};
        golden[18] = {32'hFEDCBA98, 32'h01234567, 32'hFFFFFFFF};
        golden[19] = {32'hA5A5A5A5, 32'h0000FFFF, 32'hA5A5FFFF};
        for (int i = 0; i < 20; i++) rom[i] = golden[i];
        rom1 = {32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    endtask

    // Pulses start, then counts rising edges until done (or until the reset cycle rst_at).
    // Extra start pulses are sampled at edges ig1/ig2; cycle counts are relative to the accepting edge.
    task automatic run_main(input int ig1, input int ig2, input int rst_at, output int cyc);
        cyc = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        while (cyc < 1000) begin
            @(negedge clk);
            start = (cyc == ig1 - 1) || (cyc == ig2 - 1);
            rst_n = !(cyc == rst_at - 1);
            @(posedge clk);
            cyc++;
            #1;
            if (done || cyc == rst_at) break;
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({vec_addr, dut_a, dut_b, pass_cnt, fail_cnt, first_fail, busy, done, all_pass} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got addr=%0h a=%0h b=%0h pass=%0d fail=%0d ff=%0d busy=%b done=%b ap=%b, expected all zero",
                     vec_addr, dut_a, dut_b, pass_cnt, fail_cnt, first_fail, busy, done, all_pass);
        end
        tests++;
        if ({busy1, done1, pass1} !== '0) begin
            fails++;
            $display("FAIL reset_one: got busy=%b done=%b pass=%0d expected 0", busy1, done1, pass1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_pass();
        int cyc;
        run_main(0, 0, 0, cyc);
        tests++;
        if (cyc !== 100) begin fails++; $display("FAIL full_latency: got %0d expected 100", cyc); end
        tests++;
        if (pass_cnt !== 6'd20) begin fails++; $display("FAIL full_pass_cnt: got %0d expected 20", pass_cnt); end
        tests++;
        if (fail_cnt !== 6'd0) begin fails++; $display("FAIL full_fail_cnt: got %0d expected 0", fail_cnt); end
        tests++;
        if ({all_pass, busy, done} !== 3'b101) begin
            fails++; $display("FAIL full_flags: got ap/busy/done=%b%b%b expected 101", all_pass, busy, done);
        end
        tests++;
        if ({dut_a, dut_b} !== {32'hA5A5A5A5, 32'h0000FFFF}) begin
            fails++; $display("FAIL full_hold_operands: got %0h/%0h expected a5a5a5a5/0000ffff", dut_a, dut_b);
        end
    endtask

    task automatic test_one_fail();
        int cyc;
        rom[14] = {32'h89ABCDEF, 32'h00000000, 32'h89ABCDEE};
        run_main(0, 0, 0, cyc);
        tests++;
`ifdef ALU_CHK_STOP_ON_FAIL_EN
        if ({cyc, pass_cnt, fail_cnt, first_fail} !== {32'd75, 6'd14, 6'd1, 5'd14}) begin
            fails++; $display("FAIL one_fail_stats: got cyc=%0d pass=%0d fail=%0d ff=%0d expected 75/14/1/14",
                              cyc, pass_cnt, fail_cnt, first_fail);
        end
`else
        if ({cyc, pass_cnt, fail_cnt, first_fail} !== {32'd100, 6'd19, 6'd1, 5'd14}) begin
            fails++; $display("FAIL one_fail_stats: got cyc=%0d pass=%0d fail=%0d ff=%0d expected 100/19/1/14",
                              cyc, pass_cnt, fail_cnt, first_fail);
        end
`endif
        tests++;
        if ({done, all_pass} !== 2'b10) begin
            fails++; $display("FAIL one_fail_all_pass: got done/ap=%b%b expected 10", done, all_pass);
        end
        rom[14] = golden[14];
    endtask

    task automatic test_two_fails();
        int cyc;
        rom[3] = {32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
        rom[9] = {32'h12340000, 32'h00005678, 32'h12345679};
        run_main(0, 0, 0, cyc);
        tests++;
`ifdef ALU_CHK_STOP_ON_FAIL_EN
        if ({cyc, pass_cnt, fail_cnt, first_fail} !== {32'd20, 6'd3, 6'd1, 5'd3}) begin
            fails++; $display("FAIL two_fail_stats: got cyc=%0d pass=%0d fail=%0d ff=%0d expected 20/3/1/3",
                              cyc, pass_cnt, fail_cnt, first_fail);
        end
`else
        if ({cyc, pass_cnt, fail_cnt, first_fail} !== {32'd100, 6'd18, 6'd2, 5'd3}) begin
            fails++; $display("FAIL two_fail_stats: got cyc=%0d pass=%0d fail=%0d ff=%0d expected 100/18/2/3",
                              cyc, pass_cnt, fail_cnt, first_fail);
        end
`endif
        rom[3] = golden[3];
        rom[9] = golden[9];
    endtask

    task automatic test_mid_reset();
        int cyc;
        run_main(0, 0, 37, cyc);
        tests++;
        if ({busy, done, pass_cnt, fail_cnt, first_fail, vec_addr, dut_a} !== '0) begin
            fails++; $display("FAIL mid_reset_clear: got busy=%b done=%b pass=%0d fail=%0d ff=%0d addr=%0d a=%0h expected 0",
                              busy, done, pass_cnt, fail_cnt, first_fail, vec_addr, dut_a);
        end
        run_main(0, 0, 0, cyc);
        tests++;
        if ({cyc, pass_cnt, fail_cnt, all_pass} !== {32'd100, 6'd20, 6'd0, 1'b1}) begin
            fails++; $display("FAIL mid_reset_rerun: got cyc=%0d pass=%0d fail=%0d ap=%b expected 100/20/0/1",
                              cyc, pass_cnt, fail_cnt, all_pass);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_main(10, 50, 0, cyc);
        tests++;
        if ({cyc, pass_cnt, fail_cnt} !== {32'd100, 6'd20, 6'd0}) begin
            fails++; $display("FAIL busy_start_ignored: got cyc=%0d pass=%0d fail=%0d expected 100/20/0",
                              cyc, pass_cnt, fail_cnt);
        end
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({busy, done, pass_cnt, fail_cnt, all_pass} !== {1'b1, 1'b0, 6'd0, 6'd0, 1'b0}) begin
            fails++; $display("FAIL done_restart_clear: got busy=%b done=%b pass=%0d fail=%0d ap=%b expected 1/0/0/0/0",
                              busy, done, pass_cnt, fail_cnt, all_pass);
        end
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 300 && !done; k++) @(negedge clk);
        tests++;
        if ({done, pass_cnt, fail_cnt} !== {1'b1, 6'd20, 6'd0}) begin
            fails++; $display("FAIL done_restart_rerun: got done=%b pass=%0d fail=%0d expected 1/20/0",
                              done, pass_cnt, fail_cnt);
        end
    endtask

    task automatic test_single_vector();
        int cyc;
        cyc = 0;
        @(negedge clk); start1 = 1'b1;
        @(posedge clk);
        @(negedge clk); start1 = 1'b0;
        while (cyc < 100) begin
            @(posedge clk); cyc++; #1;
            if (done1) break;
        end
        tests++;
        if (cyc !== 4) begin fails++; $display("FAIL single_latency: got %0d expected 4", cyc); end
        tests++;
        if ({pass1, fail1, all_pass1, busy1} !== {6'd1, 6'd0, 1'b1, 1'b0}) begin
            fails++; $display("FAIL single_stats: got pass=%0d fail=%0d ap=%b busy=%b expected 1/0/1/0",
                              pass1, fail1, all_pass1, busy1);
        end
    endtask

    initial begin
        init_vectors();
        test_reset();
        test_full_pass();
        test_one_fail();
        test_two_fails();
        test_mid_reset();
        test_back_to_back();
        test_single_vector();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
